// File: rtl/bcd_down_counter_pkg.sv
// Shared definitions for the cascaded BCD down-counter: decade width,
// largest legal decade value and the decade validity check.
package bcd_down_counter_pkg;

  localparam int DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;

  localparam bcd_digit_t DIGIT_MAX = 4'd9;

  // A decade is legal BCD only when it does not exceed nine.
  function automatic logic digit_valid(input bcd_digit_t d);
    return (d <= DIGIT_MAX);
  endfunction

endpackage

// File: rtl/bcd_down_counter_if.sv
// Control and status bundle of the BCD down-counter. The master drives load
// requests and the count enable; the slave (the counter) returns the count,
// terminal count and the two single-cycle status pulses.
interface bcd_down_counter_if
  import bcd_down_counter_pkg::*;
#(
  parameter int DIGITS = 3
);

  logic                      load;
  logic [DIGIT_W*DIGITS-1:0] din;
  logic                      en;
  logic [DIGIT_W*DIGITS-1:0] dout;
  logic                      tc;
  logic                      bout;
  logic                      load_err;

  modport master (
    output load, din, en,
    input  dout, tc, bout, load_err
  );

  modport slave (
    input  load, din, en,
    output dout, tc, bout, load_err
  );

endinterface

// File: rtl/bcd_digit_down.sv
// One BCD decade of the down-counter. A load overwrites the decade; a
// decrement request steps it down by one, rolling 0 over to 9. The zero flag
// feeds the borrow chain of the decades above.
module bcd_digit_down
  import bcd_down_counter_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       load,
  input  bcd_digit_t d,
  input  logic       dec_in,
  output bcd_digit_t q,
  output logic       zero
);

  // Decade register: load beats decrement, decrement at zero rolls to nine.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (dec_in) begin
      q <= (q == '0) ? DIGIT_MAX : (q - 4'd1);
    end
  end

  assign zero = (q == '0);

endmodule

// File: rtl/bcd_down_counter.sv
// Cascaded BCD down-counter of DIGITS decades. Loads are checked for legal
// BCD before being accepted; an illegal load leaves the count untouched and
// raises load_err for one cycle. At zero the counter either wraps to all
// nines (raising bout for one cycle) or sticks at zero, depending on WRAP.
module bcd_down_counter
  import bcd_down_counter_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter bit WRAP   = 1'b1
)
(
  input  logic                clk,
  input  logic                rstn,
  bcd_down_counter_if.slave   bus
);

  logic [DIGIT_W*DIGITS-1:0] count_q;
  logic [DIGITS-1:0]         digit_zero;
  logic [DIGITS-1:0]         dec_in;
  logic [DIGITS:0]           lower_zero;
  logic                      din_valid;
  logic                      all_zero;
  logic                      do_load;
  logic                      do_count;
  logic                      wrap_now;
  logic                      bout_q;
  logic                      load_err_q;

  // A load is only accepted when every decade of din is legal BCD.
  always_comb begin
    din_valid = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      din_valid = din_valid & digit_valid(bus.din[DIGIT_W*i +: DIGIT_W]);
    end
  end

  // lower_zero[i] is high when decades 0..i-1 all read zero, so it is also
  // the borrow into decade i; lower_zero[DIGITS] means the whole count is zero.
  assign lower_zero[0] = 1'b1;
  assign all_zero      = lower_zero[DIGITS];

  // Any load request, valid or not, suppresses counting for that cycle.
  // Without wrap, a zero count simply refuses to decrement.
  assign do_load  = bus.load & din_valid;
  assign do_count = bus.en & ~bus.load & (WRAP | ~all_zero);
  assign wrap_now = do_count & all_zero;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    assign lower_zero[i+1] = lower_zero[i] & digit_zero[i];
    assign dec_in[i]       = do_count & lower_zero[i];

    bcd_digit_down u_digit (
      .clk    (clk),
      .rstn   (rstn),
      .load   (do_load),
      .d      (bus.din[DIGIT_W*i +: DIGIT_W]),
      .dec_in (dec_in[i]),
      .q      (count_q[DIGIT_W*i +: DIGIT_W]),
      .zero   (digit_zero[i])
    );
  end

  // Status pulses: borrow-out after a wrap, error after a rejected load.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bout_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      bout_q     <= wrap_now;
      load_err_q <= bus.load & ~din_valid;
    end
  end

  assign bus.dout     = count_q;
  assign bus.tc       = all_zero;
  assign bus.bout     = bout_q;
  assign bus.load_err = load_err_q;

endmodule

// File: doc/bcd_down_counter.md
BCD_DOWN_COUNTER -- requirements
Module: bcd_down_counter

Interface
REQ-001 Parameter DIGITS, default 3: number of cascaded BCD decades; legal range 1..8.
REQ-002 Parameter WRAP, default 1: 1 means wrap from all-zero to all-nine; 0 means saturate at zero.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 load  input  1  parallel load request for the current cycle.
REQ-006 din  input  4*DIGITS  BCD load value; digit i occupies bits [4i+3:4i], with digit 0 least significant.
REQ-007 en  input  1  count-down enable.
REQ-008 dout  output  4*DIGITS  current BCD count, registered.
REQ-009 tc  output  1  terminal count, combinational; high exactly when dout is all zero, independent of en.
REQ-010 bout  output  1  borrow-out pulse, registered; high for one cycle after a wrap from zero to all-nines.
REQ-011 load_err  output  1  registered one-cycle pulse signalling a rejected load.

Function
REQ-012 Priority per cycle: load over en over hold.
REQ-013 On load, if every din digit is <= 9, dout takes din at the next edge; load_err = 0.
REQ-014 On load, if any din digit is > 9, the whole load is rejected: dout is unchanged, the cycle does not count (even if en = 1), and load_err = 1 for the next cycle.
REQ-015 With en = 1 and no load, dout decrements by exactly 1 in BCD at the next edge.
REQ-016 Decrement rule:
- Digit 0 always decrements.
- Digit i decrements only when digits 0..i-1 are all zero (borrow ripple).
- A decrementing digit at 0 becomes 9; otherwise it becomes d-1.
REQ-017 With dout all zero and en = 1:
- WRAP=1: dout becomes all-nines and bout = 1 in that same following cycle.
- WRAP=0: dout stays zero and bout stays 0.
REQ-018 bout is 0 in every cycle except the one immediately following a wrap; load never asserts bout.
REQ-019 With en = 0 and no load, dout holds.
REQ-020 Latency: every dout change is visible one cycle after the qualifying edge; tc follows dout combinationally with zero latency.
REQ-021 Loading zero is legal and asserts tc the next cycle.
REQ-022 Simultaneous load (valid) and en: the load wins, with no extra decrement.
REQ-023 dout never holds a digit > 9 after reset, under any input sequence.

Reset
REQ-024 While rstn = 0: dout = 0, bout = 0, load_err = 0, hence tc = 1.
REQ-025 Reset asserted mid-count overrides load and en immediately and asynchronously.
REQ-026 After rstn deasserts, the first count or load takes effect on the first rising edge at which rstn is high.

Structure
REQ-027 A shared package holds: the BCD digit width (4), the maximum digit value (9), and the digit-valid check function.
REQ-028 One sub-module, bcd_digit_down, shall implement a single decade.
- Inputs: clk, rstn, load, d, dec_in.
- Outputs: q, zero.
- The top instantiates DIGITS copies.
- The borrow chain is formed from the zero flags of the lower digits.
REQ-029 Load validation and the bout/load_err registers reside in the top level.

Verification (DIGITS=3)
REQ-030 Reset then en=1 for 3 cycles (WRAP=1) -> dout 000 -> 999 with bout=1 for one cycle, then 998, 997; tc=1 only while dout=000.
REQ-031 Load 0x100, then en=1 -> dout 100 -> 099 -> 098; digit 2 borrows correctly; bout stays 0.
REQ-032 Load 0x1A5 with en=1 while dout=0x042 -> dout stays 042 and load_err=1 for exactly one cycle.
REQ-033 load=1 din=0x010 and en=1 in the same cycle -> dout=010, no decrement; next en cycle -> 009.
REQ-034 WRAP=0: load 0x002, en=1 for 4 cycles -> 001, 000, 000, 000; bout never asserts; tc=1 from the second cycle.
REQ-035 rstn pulsed low mid-count at dout=0x537 between clock edges -> dout=000 immediately, bout=0, load_err=0; counting resumes from 000 (wrap to 999) once rstn is high.
